// File: rtl/video_timing_recover_if.sv
// Pixel-stream bundle between a sync source (master) and the timing recovery block (slave).
// CE_PIX qualifies HSYNC/VSYNC/CHBL: they are sampled only on cycles with CE_PIX=1; there is no backpressure.
interface video_timing_recover_if;
  logic       CE_PIX;
  logic       HSYNC;
  logic       VSYNC;
  logic       CHBL;
  logic [9:0] PIX_X;
  logic [8:0] PIX_Y;
  logic [9:0] LINE_LEN;
  logic [8:0] FRAME_LINES;
  logic       PAL_DET;
  logic       NTSC_DET;
  logic       LOCKED;
  logic       FRAME_START;
  logic       DE;
  logic [1:0] DBG_STATE;

  modport master (
    output CE_PIX, HSYNC, VSYNC, CHBL,
    input  PIX_X, PIX_Y, LINE_LEN, FRAME_LINES, PAL_DET, NTSC_DET, LOCKED, FRAME_START, DE, DBG_STATE
  );

  modport slave (
    input  CE_PIX, HSYNC, VSYNC, CHBL,
    output PIX_X, PIX_Y, LINE_LEN, FRAME_LINES, PAL_DET, NTSC_DET, LOCKED, FRAME_START, DE, DBG_STATE
  );
endinterface

// File: rtl/video_timing_recover.sv
// Rebuilds pixel/line position from sampled HSYNC/VSYNC/CHBL, measures line and frame length,
// and classifies a stable raster as PAL or NTSC once two clean frames agree.
module video_timing_recover #(
  parameter int H_NOM  = 384,
  parameter int H_TOL  = 2,
  parameter int V_PAL  = 312,
  parameter int V_NTSC = 264,
  parameter int H_MAX  = 1023
) (
  input  logic                  CLK_24MB,
  input  logic                  nRESETP,
  video_timing_recover_if.slave vid
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] C_H_NOM  = 10'(H_NOM);
  localparam logic [9:0] C_H_TOL  = 10'(H_TOL);
  localparam logic [9:0] C_H_MAX  = 10'(H_MAX);
  localparam logic [8:0] C_V_PAL  = 9'(V_PAL);
  localparam logic [8:0] C_V_NTSC = 9'(V_NTSC);
  localparam logic [8:0] C_V_MAX  = 9'd511;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_ref_load;
  logic       r_hs_d;
  logic       r_vs_d;
  logic       r_chbl;
  logic       r_vpend;
  logic       r_frame_bad;
  logic       r_frame_start;
  logic [9:0] r_hcnt;
  logic [9:0] r_line_len;
  logic [8:0] r_vcnt;
  logic [8:0] r_frame_lines;
  logic [8:0] r_ref_lines;

  logic       w_hs_fall;
  logic       w_vs_fall;
  logic       w_close;
  logic       w_wdog;
  logic [9:0] w_hcnt_inc;
  logic [9:0] w_line_diff;
  logic       w_line_ok;
  logic [8:0] w_vcnt_inc;
  logic       w_frame_ok;
  logic       w_clean;

  assign w_hs_fall  = vid.CE_PIX & r_hs_d & ~vid.HSYNC;
  assign w_vs_fall  = vid.CE_PIX & r_vs_d & ~vid.VSYNC;
  // A VSYNC edge landing on the same sample as the HSYNC edge closes the frame right there.
  assign w_close    = w_hs_fall & (r_vpend | w_vs_fall);
  assign w_hcnt_inc = (r_hcnt == C_H_MAX) ? C_H_MAX : r_hcnt + 10'd1;
  assign w_vcnt_inc = (r_vcnt == C_V_MAX) ? C_V_MAX : r_vcnt + 9'd1;
  assign w_wdog     = vid.CE_PIX & ~w_hs_fall & (w_hcnt_inc == C_H_MAX);

  // w_hcnt_inc is the length of the line that ends at this HSYNC edge.
  assign w_line_diff = (w_hcnt_inc >= C_H_NOM) ? (w_hcnt_inc - C_H_NOM) : (C_H_NOM - w_hcnt_inc);
  assign w_line_ok   = (w_line_diff <= C_H_TOL);
  assign w_frame_ok  = (w_vcnt_inc == C_V_PAL) | (w_vcnt_inc == C_V_NTSC);
  assign w_clean     = ~r_frame_bad & w_line_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_ref_load  = 1'b0;
    if (w_wdog) begin
      w_state_nxt = ST_SEARCH;
    end else if (w_hs_fall) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_close & w_clean & w_frame_ok) begin
            w_state_nxt = ST_MEASURE;
            w_ref_load  = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_close) begin
            w_state_nxt = (w_clean & (w_vcnt_inc == r_ref_lines)) ? ST_LOCKED : ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (~w_line_ok | (w_close & (w_vcnt_inc != r_ref_lines))) begin
            w_state_nxt = ST_SEARCH;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLK_24MB) begin
    if (!nRESETP) r_state <= ST_SEARCH;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK_24MB) begin
    if (!nRESETP) begin
      r_hs_d        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_chbl        <= 1'b1;
      r_vpend       <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_frame_start <= 1'b0;
      r_hcnt        <= '0;
      r_line_len    <= '0;
      r_vcnt        <= '0;
      r_frame_lines <= '0;
      r_ref_lines   <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_ref_load) r_ref_lines <= w_vcnt_inc;
      if (vid.CE_PIX) begin
        r_hs_d <= vid.HSYNC;
        r_vs_d <= vid.VSYNC;
        r_chbl <= vid.CHBL;
        if (w_hs_fall) begin
          r_hcnt     <= '0;
          r_line_len <= w_hcnt_inc;
          if (w_close) begin
            r_frame_lines <= w_vcnt_inc;
            r_vcnt        <= '0;
            r_vpend       <= 1'b0;
            r_frame_start <= 1'b1;
            r_frame_bad   <= 1'b0;
          end else begin
            r_vcnt      <= w_vcnt_inc;
            r_frame_bad <= r_frame_bad | ~w_line_ok;
          end
        end else begin
          r_hcnt  <= w_hcnt_inc;
          r_vpend <= r_vpend | w_vs_fall;
        end
      end
    end
  end

  assign vid.PIX_X       = r_hcnt;
  assign vid.PIX_Y       = r_vcnt;
  assign vid.LINE_LEN    = r_line_len;
  assign vid.FRAME_LINES = r_frame_lines;
  assign vid.LOCKED      = (r_state == ST_LOCKED);
  assign vid.PAL_DET     = (r_state == ST_LOCKED) & (r_frame_lines == C_V_PAL);
  assign vid.NTSC_DET    = (r_state == ST_LOCKED) & (r_frame_lines == C_V_NTSC);
  assign vid.FRAME_START = r_frame_start;
  assign vid.DE          = (r_state == ST_LOCKED) & ~r_chbl;
  assign vid.DBG_STATE   = r_state;

endmodule

// File: tb/tb_video_timing_recover.sv
// Directed bench for video_timing_recover on a scaled-down raster (16 px lines, 11/13-line frames).
module tb_video_timing_recover;
  localparam int H_NOM  = 16;
  localparam int H_TOL  = 2;
  localparam int V_PAL  = 13;
  localparam int V_NTSC = 11;
  localparam int H_MAX  = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_recover_if vif();

  video_timing_recover #(
    .H_NOM(H_NOM), .H_TOL(H_TOL), .V_PAL(V_PAL), .V_NTSC(V_NTSC), .H_MAX(H_MAX)
  ) dut (
    .CLK_24MB(clk),
    .nRESETP (rst_n),
    .vid     (vif)
  );

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int fs0;
  int tb_vcnt = 0;
  bit tb_vpend = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Every FRAME_START must match a frame close predicted by the line driver.
  always @(negedge clk) begin
    if (rst_n && vif.FRAME_START === 1'b1) begin
      fs_cnt++;
      if (exp_q.size() == 0) chk("fs_unexpected", 1, 0);
      else chk("frame_lines_q", vif.FRAME_LINES, exp_q.pop_front());
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic pix(input logic hs, input logic vs, input logic bl);
    @(negedge clk); vif.CE_PIX = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    vif.HSYNC = hs; vif.VSYNC = vs; vif.CHBL = bl; vif.CE_PIX = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk); vif.CE_PIX = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic line(input int len, input bit vs_fall, input bit vs_same);
    if (tb_vpend || vs_same) begin
      exp_q.push_back(9'(tb_vcnt + 1));
      tb_vcnt = 0;
      tb_vpend = 0;
    end else begin
      tb_vcnt = (tb_vcnt == 511) ? 511 : tb_vcnt + 1;
    end
    for (int p = 0; p < len; p++) begin
      logic hs_v, vs_v;
      hs_v = (p < 2) ? 1'b0 : 1'b1;
      vs_v = ((vs_same && p < 4) || (vs_fall && p >= 5)) ? 1'b0 : 1'b1;
      pix(hs_v, vs_v, (p < 4) ? 1'b1 : 1'b0);
    end
    if (vs_fall) tb_vpend = 1;
  endtask

  task automatic lines(input int n, input int len, input bit vs_last);
    for (int i = 0; i < n; i++) line(len, vs_last && (i == n - 1), 1'b0);
  endtask

  task automatic frame(input int n);
    lines(n, H_NOM, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_x"}, vif.PIX_X, 0);
    chk({tag, "_pix_y"}, vif.PIX_Y, 0);
    chk({tag, "_line_len"}, vif.LINE_LEN, 0);
    chk({tag, "_frame_lines"}, vif.FRAME_LINES, 0);
    chk({tag, "_pal"}, vif.PAL_DET, 0);
    chk({tag, "_ntsc"}, vif.NTSC_DET, 0);
    chk({tag, "_locked"}, vif.LOCKED, 0);
    chk({tag, "_fs"}, vif.FRAME_START, 0);
    chk({tag, "_de"}, vif.DE, 0);
    chk({tag, "_state"}, vif.DBG_STATE, 0);
  endtask

  initial begin
    vif.CE_PIX = 1'b0; vif.HSYNC = 1'b1; vif.VSYNC = 1'b1; vif.CHBL = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // NTSC: first close is partial, then two clean frames to lock
    repeat (3) frame(V_NTSC);
    chk("ntsc_f3_locked", vif.LOCKED, 0);
    chk("ntsc_f3_state", vif.DBG_STATE, 1);
    frame(V_NTSC);
    chk("ntsc_locked", vif.LOCKED, 1);
    chk("ntsc_det", vif.NTSC_DET, 1);
    chk("ntsc_pal_det", vif.PAL_DET, 0);
    chk("ntsc_line_len", vif.LINE_LEN, 16);
    chk("ntsc_frame_lines", vif.FRAME_LINES, 11);
    chk("ntsc_pix_x", vif.PIX_X, 15);
    chk("ntsc_pix_y", vif.PIX_Y, 10);
    chk("ntsc_de", vif.DE, 1);
    chk("ntsc_state", vif.DBG_STATE, 2);

    idle(7);
    chk("ce_hold_pix_x", vif.PIX_X, 15);
    chk("ce_hold_pix_y", vif.PIX_Y, 10);

    // One stretched line drops lock at the HSYNC that measures it
    lines(4, H_NOM, 1'b0);
    chk("stretch_pre_locked", vif.LOCKED, 1);
    lines(1, 22, 1'b0);
    chk("stretch_mid_locked", vif.LOCKED, 1);
    chk("stretch_mid_pix_x", vif.PIX_X, 21);
    lines(1, H_NOM, 1'b0);
    chk("stretch_drop_locked", vif.LOCKED, 0);
    chk("stretch_line_len", vif.LINE_LEN, 22);
    chk("stretch_state", vif.DBG_STATE, 0);
    lines(5, H_NOM, 1'b1);
    frame(V_NTSC);
    frame(V_NTSC);
    chk("relock_c2_locked", vif.LOCKED, 0);
    chk("relock_c2_state", vif.DBG_STATE, 1);
    frame(V_NTSC);
    chk("relock_locked", vif.LOCKED, 1);

    // PAL
    frame(V_PAL);
    chk("pal1_locked", vif.LOCKED, 1);
    chk("pal1_ntsc", vif.NTSC_DET, 1);
    frame(V_PAL);
    chk("pal2_locked", vif.LOCKED, 0);
    chk("pal2_frame_lines", vif.FRAME_LINES, 13);
    frame(V_PAL);
    chk("pal3_state", vif.DBG_STATE, 1);
    frame(V_PAL);
    chk("pal_locked", vif.LOCKED, 1);
    chk("pal_det", vif.PAL_DET, 1);
    chk("pal_ntsc_det", vif.NTSC_DET, 0);
    chk("pal_pix_y", vif.PIX_Y, 12);
    chk("pal_de", vif.DE, 1);
    fs0 = fs_cnt;
    frame(V_PAL);
    chk("pal_fs_per_frame", fs_cnt - fs0, 1);

    // Missing HSYNC: watchdog at H_MAX
    line(1023, 1'b0, 1'b0);
    chk("wdog_pre_pix_x", vif.PIX_X, 1022);
    chk("wdog_pre_locked", vif.LOCKED, 1);
    chk("wdog_pre_pix_y", vif.PIX_Y, 0);
    pix(1'b1, 1'b1, 1'b0);
    chk("wdog_pix_x", vif.PIX_X, 1023);
    chk("wdog_locked", vif.LOCKED, 0);
    chk("wdog_state", vif.DBG_STATE, 0);
    chk("wdog_de", vif.DE, 0);
    repeat (4) pix(1'b1, 1'b1, 1'b0);
    chk("wdog_sat_pix_x", vif.PIX_X, 1023);
    line(H_NOM, 1'b0, 1'b0);
    chk("wdog_line_len", vif.LINE_LEN, 1023);
    chk("wdog_pix_y", vif.PIX_Y, 1);

    // VSYNC and HSYNC falling on the same sample
    lines(3, H_NOM, 1'b0);
    fs0 = fs_cnt;
    line(H_NOM, 1'b0, 1'b1);
    chk("same_pix_y", vif.PIX_Y, 0);
    chk("same_frame_lines", vif.FRAME_LINES, 5);
    chk("same_fs", fs_cnt - fs0, 1);
    lines(10, H_NOM, 1'b1);
    frame(V_NTSC);
    chk("same_next_frame_lines", vif.FRAME_LINES, 11);
    chk("same_next_state", vif.DBG_STATE, 1);
    frame(V_NTSC);
    chk("prereset_locked", vif.LOCKED, 1);

    // Reset mid-frame while locked
    lines(5, H_NOM, 1'b0);
    chk("midframe_locked", vif.LOCKED, 1);
    @(negedge clk); vif.CE_PIX = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tb_vcnt = 0; tb_vpend = 0; exp_q.delete();
    chk_zero("midrst");
    idle(5);
    chk("midrst_hold_pix_x", vif.PIX_X, 0);
    lines(6, H_NOM, 1'b1);
    frame(V_NTSC);
    frame(V_NTSC);
    chk("rst_relock_f2_locked", vif.LOCKED, 0);
    chk("rst_relock_f2_state", vif.DBG_STATE, 1);
    frame(V_NTSC);
    chk("rst_relock_locked", vif.LOCKED, 1);
    chk("rst_relock_ntsc", vif.NTSC_DET, 1);

    idle(4);
    chk("fs_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
